// File: rtl/see_stuff_sink.sv
// Item sink: buffers 5-bit items in a small FIFO, drains them into a running
// sum/count, and publishes the batch totals on a notify/ack handshake.
module see_stuff_sink #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cStuffIf_vld,
  input  logic [4:0]               cStuffIf_data,
  output logic                     cStuffIf_rdy,
  input  logic                     startDone_notify,
  output logic                     startDone_ack,
  input  logic                     drain_en,
  output logic [11:0]              done_sum,
  output logic [CNT_W-1:0]         done_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, ACK, WAITLOW} state_t;

  state_t             state, state_next;
  logic [4:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        level, level_next;
  logic [11:0]        run_sum;
  logic [CNT_W-1:0]   run_cnt;
  logic               push, pop;

  always_comb begin
    push       = cStuffIf_vld && cStuffIf_rdy;
    pop        = (level != '0) && ((state == RUN && drain_en) || state == FLUSH);
    level_next = level + (AW+1)'(push) - (AW+1)'(pop);
    state_next = state;
    case (state)
      RUN:     if (startDone_notify) state_next = FLUSH;
      // No pushes happen in FLUSH, so level_next == 0 means the last pop is now.
      FLUSH:   if (level_next == '0) state_next = ACK;
      ACK:     state_next = WAITLOW;
      WAITLOW: if (!startDone_notify) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      run_sum       <= '0;
      run_cnt       <= '0;
      done_sum      <= '0;
      done_cnt      <= '0;
      startDone_ack <= 1'b0;
      cStuffIf_rdy  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= state_next;
      level <= level_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (state == ACK) begin
        done_sum <= run_sum;
        done_cnt <= run_cnt;
        run_sum  <= '0;
        run_cnt  <= '0;
      end else if (pop) begin
        run_sum <= run_sum + 12'(mem[rd_ptr]);
        if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
      end
      // Outputs are registered from next-state values so they line up with the state.
      startDone_ack <= (state_next == ACK);
      cStuffIf_rdy  <= (state_next == RUN) && (level_next < FULL_LEVEL);
      busy          <= (state_next != RUN) || (level_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cStuffIf_data;
  end

  assign fifo_level = level;

endmodule

// File: tb/tb_see_stuff_sink.sv
// Scenario bench for see_stuff_sink: directed handshake cases plus random
// batches checked against a queue-based model of the FIFO and batch totals.
module tb_see_stuff_sink;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [4:0]  data = '0;
  logic        notify = 1'b0;
  logic        drain = 1'b0;

  logic        rdy, ack, busy;
  logic [11:0] done_sum;
  logic [7:0]  done_cnt;
  logic [2:0]  level;

  logic        rdy4, ack4, busy4;
  logic [11:0] done_sum4;
  logic [3:0]  done_cnt4;
  logic [2:0]  level4;

  int vectors = 0;
  int errors  = 0;

  see_stuff_sink #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cStuffIf_vld(vld), .cStuffIf_data(data),
    .cStuffIf_rdy(rdy), .startDone_notify(notify), .startDone_ack(ack),
    .drain_en(drain), .done_sum(done_sum), .done_cnt(done_cnt),
    .fifo_level(level), .busy(busy)
  );

  // Narrow counter instance shares stimulus; used for the saturation case.
  see_stuff_sink #(.DEPTH(DEPTH), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .cStuffIf_vld(vld), .cStuffIf_data(data),
    .cStuffIf_rdy(rdy4), .startDone_notify(notify), .startDone_ack(ack4),
    .drain_en(drain), .done_sum(done_sum4), .done_cnt(done_cnt4),
    .fifo_level(level4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic close_batch(input int es, input int ec, input int ec4, input string name);
    int n;
    bit got;
    int extra;
    n = 0; got = 0; extra = 0;
    vld = 1'b0;
    notify = 1'b1;
    while (!got && n < 40) begin
      step();
      n++;
      if (ack === 1'b1) got = 1;
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack_timeout: no ack within %0d cycles, required an ack", name, n);
    end
    notify = 1'b0;
    step();
    vectors++;
    if (done_sum !== 12'(es)) begin
      errors++;
      $display("FAIL %s done_sum: got %0d required %0d", name, done_sum, es);
    end
    vectors++;
    if (done_cnt !== 8'(ec)) begin
      errors++;
      $display("FAIL %s done_cnt: got %0d required %0d", name, done_cnt, ec);
    end
    vectors++;
    if (done_sum4 !== 12'(es) || done_cnt4 !== 4'(ec4)) begin
      errors++;
      $display("FAIL %s w4_totals: got sum %0d cnt %0d required sum %0d cnt %0d",
               name, done_sum4, done_cnt4, es, ec4);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack !== 1'b0) extra++;
    end
    vectors++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s extra_ack: got %0d extra acks required 0", name, extra);
    end
    $display("batch %s: done_sum=%0d done_cnt=%0d ack_after=%0d", name, done_sum, done_cnt, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (rdy !== 1'b0 || level !== 3'd0 || ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b level=%0d ack=%b busy=%b required 0 0 0 0",
               rdy, level, ack, busy);
    end
    vectors++;
    if (done_sum !== 12'd0 || done_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_done: got sum=%0d cnt=%0d required 0 0", done_sum, done_cnt);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: got %b required 1", rdy);
    end
    $display("reset: rdy=%b level=%0d busy=%b", rdy, level, busy);
  endtask

  task automatic test_reset_flush();
    drain = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1;
      data = 5'($urandom_range(1, 31));
      step();
    end
    vld = 1'b0;
    vectors++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL rstflush_fill: got level %0d required 3", level);
    end
    notify = 1'b1;
    step();
    rst = 1'b1;
    notify = 1'b0;
    step();
    vectors++;
    if (level !== 3'd0 || ack !== 1'b0 || done_sum !== 12'd0) begin
      errors++;
      $display("FAIL rstflush_state: got level=%0d ack=%b sum=%0d required 0 0 0",
               level, ack, done_sum);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (rdy !== 1'b1 || ack !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL rstflush_release: got rdy=%b ack=%b level=%0d required 1 0 0", rdy, ack, level);
    end
    $display("reset mid-flush: level=%0d rdy=%b done_sum=%0d", level, rdy, done_sum);
  endtask

  task automatic test_empty();
    int n;
    int extra;
    n = 0; extra = 0;
    notify = 1'b1;
    while (ack !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (n != 2) begin
      errors++;
      $display("FAIL empty_ack_latency: got %0d cycles required 2", n);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack !== 1'b0) extra++;
    end
    vectors++;
    if (extra != 0 || done_sum !== 12'd0 || done_cnt !== 8'd0) begin
      errors++;
      $display("FAIL empty_batch: got extra=%0d sum=%0d cnt=%0d required 0 0 0", extra, done_sum, done_cnt);
    end
    notify = 1'b0;
    step();
    step();
    $display("empty batch: ack_after=%0d done_sum=%0d done_cnt=%0d", n, done_sum, done_cnt);
  endtask

  task automatic test_stream();
    logic [4:0] items [3];
    items[0] = 5'd3; items[1] = 5'd7; items[2] = 5'd31;
    drain = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1;
      data = items[i];
      vectors++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL stream_rdy[%0d]: got %b required 1", i, rdy);
      end
      step();
    end
    vld = 1'b0;
    vectors++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL stream_level_busy: got %0d required 1", level);
    end
    step();
    vectors++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL stream_level_drained: got %0d required 0", level);
    end
    close_batch(41, 3, 3, "stream");
  endtask

  task automatic test_backpressure();
    logic [4:0] items [5];
    int total;
    total = 0;
    drain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      items[i] = 5'($urandom_range(0, 31));
      total += int'(items[i]);
    end
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1;
      data = items[i];
      step();
    end
    data = items[4];
    vectors++;
    if (rdy !== 1'b0 || level !== 3'd4) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b level=%0d required 0 4", rdy, level);
    end
    drain = 1'b1;
    step();
    vectors++;
    if (rdy !== 1'b1 || level !== 3'd3) begin
      errors++;
      $display("FAIL bp_freed: got rdy=%b level=%0d required 1 3", rdy, level);
    end
    step();
    vld = 1'b0;
    close_batch(total, 5, 5, "backpressure");
  endtask

  task automatic test_flush();
    int ack_at;
    int rdy_high;
    ack_at = -1; rdy_high = 0;
    drain = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1;
      data = 5'd31;
      step();
    end
    vld = 1'b0;
    notify = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (rdy !== 1'b0) rdy_high++;
      if (ack === 1'b1 && ack_at < 0) ack_at = k;
    end
    vectors++;
    if (rdy_high != 0) begin
      errors++;
      $display("FAIL flush_rdy: got rdy high %0d cycles required 0", rdy_high);
    end
    vectors++;
    if (ack_at != 5) begin
      errors++;
      $display("FAIL flush_ack_latency: got %0d required 5", ack_at);
    end
    notify = 1'b0;
    step();
    vectors++;
    if (done_sum !== 12'd124 || done_cnt !== 8'd4) begin
      errors++;
      $display("FAIL flush_totals: got sum=%0d cnt=%0d required 124 4", done_sum, done_cnt);
    end
    step();
    step();
    $display("flush: ack_at=%0d done_sum=%0d done_cnt=%0d", ack_at, done_sum, done_cnt);
  endtask

  task automatic test_wrap();
    int n;
    int guard;
    n = 0; guard = 0;
    drain = 1'b1;
    while (n < 140 && guard < 1000) begin
      vld = 1'b1;
      data = 5'd31;
      if (rdy === 1'b1) n++;
      step();
      guard++;
    end
    vld = 1'b0;
    close_batch((140 * 31) % 4096, 140, 15, "wrap");
  endtask

  task automatic test_random();
    logic [4:0] q [$];
    int sum, cnt, cycles;
    bit exp_rdy;
    bit v, d;
    logic [4:0] x;
    for (int b = 0; b < 4; b++) begin
      q.delete();
      sum = 0; cnt = 0;
      cycles = $urandom_range(20, 60);
      for (int c = 0; c < cycles; c++) begin
        exp_rdy = (q.size() < DEPTH);
        vectors++;
        if (rdy !== exp_rdy || level !== 3'(q.size())) begin
          errors++;
          $display("FAIL random_b%0d_c%0d: got rdy=%b level=%0d required %b %0d",
                   b, c, rdy, level, exp_rdy, q.size());
        end
        v = 1'($urandom_range(0, 1));
        d = ($urandom_range(0, 3) != 0);
        x = 5'($urandom_range(0, 31));
        vld = v; data = x; drain = d;
        if (q.size() > 0 && d) begin
          sum += int'(q.pop_front());
          cnt++;
        end
        if (v && exp_rdy) q.push_back(x);
        step();
      end
      vld = 1'b0;
      while (q.size() > 0) begin
        sum += int'(q.pop_front());
        cnt++;
      end
      close_batch(sum % 4096, (cnt > 255) ? 255 : cnt, (cnt > 15) ? 15 : cnt, $sformatf("random%0d", b));
    end
  endtask

  initial begin
    test_reset();
    test_reset_flush();
    test_empty();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
